// File: rtl/uart_pkg.sv
// Shared state encoding, parity modes and helper functions for the UART receiver.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;

  // Clock cycles per bit, rounded to the nearest integer.
  function automatic int baud_div(input int clk_hz, input int baud);
    return (clk_hz + baud / 2) / baud;
  endfunction

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

  // Expected parity bit; unused upper data bits must be zero.
  function automatic logic parity_bit(input logic [8:0] d, input int mode);
    return (mode == PAR_ODD) ? ~(^d) : (^d);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Show-ahead receive FIFO. The head entry is held in a register, so it keeps
// its last value once the FIFO drains. Push while full is accepted only with a pop.
module uart_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]    cnt_q, cnt_d, rem_s;
  logic [WIDTH-1:0] head_q, head_d;
  logic             full_q, full_d, empty_q, empty_d;
  logic             do_push_s, do_pop_s;

  // Next pointers, occupancy and head entry.
  always_comb begin
    do_pop_s  = pop & ~empty_q;
    do_push_s = push & (~full_q | do_pop_s);
    rem_s     = cnt_q - CW'(do_pop_s);
    wr_ptr_d  = do_push_s ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d  = do_pop_s ? rd_ptr_q + PW'(1) : rd_ptr_q;
    cnt_d     = rem_s + CW'(do_push_s);
    full_d    = (cnt_d == CW'(DEPTH));
    empty_d   = (cnt_d == {CW{1'b0}});
    // A push into a (logically) empty FIFO becomes the head straight away.
    if (do_push_s && rem_s == {CW{1'b0}}) begin
      head_d = wdata;
    end else if (do_pop_s && rem_s != {CW{1'b0}}) begin
      head_d = mem_q[rd_ptr_d];
    end else begin
      head_d = head_q;
    end
  end

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (do_push_s) begin
      mem_q[wr_ptr_q] <= wdata;
    end
  end

  // Control and head registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= {PW{1'b0}};
      rd_ptr_q <= {PW{1'b0}};
      cnt_q    <= {CW{1'b0}};
      head_q   <= {WIDTH{1'b0}};
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      head_q   <= head_d;
      full_q   <= full_d;
      empty_q  <= empty_d;
    end
  end

  assign rdata = head_q;
  assign full  = full_q;
  assign empty = empty_q;

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver: synchroniser, 3-sample majority vote, framing and
// parity flags, show-ahead FIFO with sticky overrun. Parity bit: UART_RX_PARITY_EN.
module uart_rx_param #(
  parameter int CLK_HZ     = 100000000,
  parameter int BAUD       = 115200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY     = 0,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 CLK,
  input  logic                 RST_N,
  input  logic                 RX,
  input  logic                 DATA_RETRIEVED,
  output logic [DATA_BITS-1:0] DATA,
  output logic                 DATA_READY,
  output logic                 FRAME_ERR,
  output logic                 PARITY_ERR,
  output logic                 OVERRUN
);
  import uart_pkg::*;

  localparam int DIV  = baud_div(CLK_HZ, BAUD);
  localparam int HALF = DIV / 2;
  localparam int CW   = $clog2(DIV);
`ifdef UART_RX_PARITY_EN
  localparam bit PAR_ON = (PARITY != PAR_NONE);
  localparam int EW     = DATA_BITS + 2;
`else
  localparam int EW     = DATA_BITS + 1;
`endif

  if (DIV < 16) begin : g_div_chk
    $error("uart_rx_param: clock/baud divisor below 16");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9 || PARITY < 0 || PARITY > 2 ||
      FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_par_chk
    $error("uart_rx_param: illegal parameter value");
  end

  uart_state_e          state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [3:0]           bit_q, bit_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 s0_q, s0_d, s1_q, s1_d;
  logic                 par_err_q, par_err_d;
  logic                 rx_meta_q, rx_sync_q, rx_prev_q;
  logic                 overrun_q, overrun_d;
  logic                 vote_s, decide_s, push_s, frame_err_s, pop_ok_s;
  logic                 fifo_full_s, fifo_empty_s;
  logic [EW-1:0]        entry_s, head_s;

  // Receive FSM next state; bit decisions happen on the third vote sample.
  always_comb begin
    state_d     = state_q;
    cnt_d       = (cnt_q == CW'(DIV - 1)) ? {CW{1'b0}} : cnt_q + CW'(1);
    bit_d       = bit_q;
    shift_d     = shift_q;
    par_err_d   = par_err_q;
    s0_d        = (cnt_q == CW'(HALF - 1)) ? rx_sync_q : s0_q;
    s1_d        = (cnt_q == CW'(HALF)) ? rx_sync_q : s1_q;
    vote_s      = maj3(s0_q, s1_q, rx_sync_q);
    decide_s    = (cnt_q == CW'(HALF + 1));
    push_s      = 1'b0;
    frame_err_s = 1'b0;
    case (state_q)
      IDLE: begin
        // The edge-detect cycle counts as bit time 0.
        cnt_d     = CW'(1);
        bit_d     = 4'd0;
        par_err_d = 1'b0;
        state_d   = (!rx_sync_q && rx_prev_q) ? START : IDLE;
      end
      START: begin
        if (decide_s) begin
          state_d = vote_s ? IDLE : uart_pkg::DATA;
        end else begin
          state_d = START;
        end
      end
      uart_pkg::DATA: begin
        if (decide_s) begin
          shift_d = {vote_s, shift_q[DATA_BITS-1:1]};
          if (bit_q == 4'(DATA_BITS - 1)) begin
            bit_d = 4'd0;
`ifdef UART_RX_PARITY_EN
            state_d = PAR_ON ? uart_pkg::PARITY : STOP;
`else
            state_d = STOP;
`endif
          end else begin
            bit_d = bit_q + 4'd1;
          end
        end else begin
          state_d = uart_pkg::DATA;
        end
      end
`ifdef UART_RX_PARITY_EN
      uart_pkg::PARITY: begin
        if (decide_s) begin
          par_err_d = (vote_s != parity_bit(9'(shift_q), PARITY));
          state_d   = STOP;
        end else begin
          state_d = uart_pkg::PARITY;
        end
      end
`endif
      STOP: begin
        if (decide_s) begin
          push_s      = 1'b1;
          frame_err_s = ~vote_s;
          state_d     = IDLE;
        end else begin
          state_d = STOP;
        end
      end
      default: state_d = IDLE;
    endcase
`ifdef UART_RX_PARITY_EN
    entry_s = {frame_err_s, par_err_q, shift_q};
`else
    entry_s = {frame_err_s, shift_q};
`endif
  end

  // Sticky overrun: set when a frame is dropped, cleared by an accepted pop.
  always_comb begin
    pop_ok_s = DATA_RETRIEVED & ~fifo_empty_s;
    if (push_s && fifo_full_s && !pop_ok_s) begin
      overrun_d = 1'b1;
    end else if (pop_ok_s) begin
      overrun_d = 1'b0;
    end else begin
      overrun_d = overrun_q;
    end
  end

  // Synchroniser, edge history and FSM registers.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      state_q   <= IDLE;
      cnt_q     <= {CW{1'b0}};
      bit_q     <= 4'd0;
      shift_q   <= {DATA_BITS{1'b0}};
      s0_q      <= 1'b1;
      s1_q      <= 1'b1;
      par_err_q <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      rx_meta_q <= RX;
      rx_sync_q <= rx_meta_q;
      rx_prev_q <= rx_sync_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bit_q     <= bit_d;
      shift_q   <= shift_d;
      s0_q      <= s0_d;
      s1_q      <= s1_d;
      par_err_q <= par_err_d;
      overrun_q <= overrun_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH(EW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk  (CLK),
    .rst_n(RST_N),
    .push (push_s),
    .wdata(entry_s),
    .pop  (DATA_RETRIEVED),
    .rdata(head_s),
    .full (fifo_full_s),
    .empty(fifo_empty_s)
  );

  assign DATA       = head_s[DATA_BITS-1:0];
  assign FRAME_ERR  = head_s[EW-1];
  assign DATA_READY = ~fifo_empty_s;
  assign OVERRUN    = overrun_q;
`ifdef UART_RX_PARITY_EN
  assign PARITY_ERR = head_s[DATA_BITS];
`else
  assign PARITY_ERR = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_param.sv
// Directed bench for uart_rx_param: one default-rate instance for the latency and
// glitch cases, one fast instance (divisor 16, even parity) for everything else.
module tb_uart_rx_param;

  localparam int FDIV = 16;
  localparam int DDIV = 868;
  // Pin fall to DATA_READY: 2 sync + (HALF+1) + 9*DIV to the push, +1 to ready.
  localparam int DLAT = 2 + (DDIV / 2 + 1) + 9 * DDIV + 1;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       rx_f, rx_d, rr_f, rr_d;
  logic [7:0] data_f, data_d;
  logic       rdy_f, rdy_d, fe_f, fe_d, pe_f, pe_d, ovr_f, ovr_d;
  int         checks_cnt = 0;
  int         errors_cnt = 0;
  int         cyc;

  always #5 clk = ~clk;

  uart_rx_param u_dut_def (
    .CLK(clk), .RST_N(rst_n), .RX(rx_d), .DATA_RETRIEVED(rr_d),
    .DATA(data_d), .DATA_READY(rdy_d), .FRAME_ERR(fe_d),
    .PARITY_ERR(pe_d), .OVERRUN(ovr_d)
  );

  uart_rx_param #(
    .CLK_HZ(1600000), .BAUD(100000), .DATA_BITS(8), .PARITY(2), .FIFO_DEPTH(4)
  ) u_dut (
    .CLK(clk), .RST_N(rst_n), .RX(rx_f), .DATA_RETRIEVED(rr_f),
    .DATA(data_f), .DATA_READY(rdy_f), .FRAME_ERR(fe_f),
    .PARITY_ERR(pe_f), .OVERRUN(ovr_f)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Drives n bits LSB first, div cycles each; caller is 1 time unit after a posedge.
  task automatic send_bits(input bit on_def, input int div, input logic [11:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      if (on_def) rx_d = bits[i];
      else        rx_f = bits[i];
      repeat (div) @(posedge clk);
      #1;
    end
  endtask

  task automatic send_fast(input logic [7:0] d, input logic par, input logic stop);
`ifdef UART_RX_PARITY_EN
    send_bits(1'b0, FDIV, {1'b0, stop, par, d, 1'b0}, 11);
`else
    if (par === 1'bx) $display("unexpected parity argument");
    send_bits(1'b0, FDIV, {2'b00, stop, d, 1'b0}, 10);
`endif
  endtask

  task automatic pop(input bit on_def);
    if (on_def) rr_d = 1'b1;
    else        rr_f = 1'b1;
    @(posedge clk);
    #1;
    rr_d = 1'b0;
    rr_f = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0;
    rx_f  = 1'b1;
    rx_d  = 1'b1;
    rr_f  = 1'b0;
    rr_d  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_val("rst_ready", rdy_f, 1'b0);
    check_val("rst_data", data_f, 8'h00);
    check_val("rst_fe", fe_f, 1'b0);
    check_val("rst_pe", pe_f, 1'b0);
    check_val("rst_ovr", ovr_f, 1'b0);
    check_val("rst_ready_def", rdy_d, 1'b0);
    rst_n = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Default rate: 0xA5 and its latency from the pin falling edge.
    cyc = 0;
    fork
      send_bits(1'b1, DDIV, {2'b00, 1'b1, 8'hA5, 1'b0}, 10);
      begin
        while (!rdy_d && cyc < 9000) begin
          @(posedge clk);
          #1;
          cyc++;
        end
      end
    join
    check_val("lat_def", (cyc >= DLAT - 2 && cyc <= DLAT + 2) ? DLAT : cyc, DLAT);
    check_val("data_def", data_d, 8'hA5);
    check_val("fe_def", fe_d, 1'b0);
    check_val("pe_def", pe_d, 1'b0);
    pop(1'b1);
    check_val("pop_ready_def", rdy_d, 1'b0);

    // 200-cycle glitch is shorter than half a bit: false start.
    rx_d = 1'b0;
    repeat (200) @(posedge clk);
    #1;
    rx_d = 1'b1;
    repeat (1000) @(posedge clk);
    #1;
    check_val("glitch_ready", rdy_d, 1'b0);

    // Framing error, then RX held low must not start another frame.
    send_fast(8'h3C, ^8'h3C, 1'b0);
    check_val("fe_ready", rdy_f, 1'b1);
    check_val("fe_data", data_f, 8'h3C);
    check_val("fe_flag", fe_f, 1'b1);
    pop(1'b0);
    repeat (100) @(posedge clk);
    #1;
    check_val("break_ready", rdy_f, 1'b0);
    rx_f = 1'b1;
    repeat (3 * FDIV) @(posedge clk);
    #1;

    // Five back-to-back frames into a 4-deep FIFO.
    for (int i = 0; i < 5; i++) begin
      send_fast(8'h11 + 8'(i), ^(8'h11 + 8'(i)), 1'b1);
    end
    check_val("ovr_set", ovr_f, 1'b1);
    check_val("ovr_head", data_f, 8'h11);
    check_val("ovr_head_fe", fe_f, 1'b0);
    pop(1'b0);
    check_val("ovr_clear", ovr_f, 1'b0);
    check_val("pop1", data_f, 8'h12);
    pop(1'b0);
    check_val("pop2", data_f, 8'h13);
    pop(1'b0);
    check_val("pop3", data_f, 8'h14);
    check_val("pop3_ready", rdy_f, 1'b1);
    pop(1'b0);
    check_val("pop4_ready", rdy_f, 1'b0);
    pop(1'b0);
    check_val("pop_empty_data", data_f, 8'h14);

`ifdef UART_RX_PARITY_EN
    send_fast(8'h01, 1'b0, 1'b1);
    check_val("par_bad_data", data_f, 8'h01);
    check_val("par_bad_flag", pe_f, 1'b1);
    pop(1'b0);
    send_fast(8'h01, 1'b1, 1'b1);
    check_val("par_good_flag", pe_f, 1'b0);
    check_val("par_good_ready", rdy_f, 1'b1);
`else
    send_fast(8'h01, 1'b1, 1'b1);
    check_val("nopar_data", data_f, 8'h01);
    check_val("nopar_flag", pe_f, 1'b0);
`endif

    // Reset during bit 4 of 0xC3 with 0x01 still queued.
    send_bits(1'b0, FDIV, {2'b00, 1'b1, 8'hC3, 1'b0}, 5);
    rx_f = 1'b0;
    repeat (FDIV / 2) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_ready", rdy_f, 1'b0);
    check_val("mid_rst_data", data_f, 8'h00);
    check_val("mid_rst_fe", fe_f, 1'b0);
    check_val("mid_rst_ovr", ovr_f, 1'b0);
    rx_f = 1'b1;
    repeat (20) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (3 * FDIV) @(posedge clk);
    #1;
    check_val("post_rst_ready", rdy_f, 1'b0);
    send_fast(8'h5A, ^8'h5A, 1'b1);
    check_val("resend_data", data_f, 8'h5A);
    check_val("resend_ready", rdy_f, 1'b1);
    pop(1'b0);
    check_val("resend_only", rdy_f, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
